// File: rtl/ni_pkt_tx.sv
// ni_pkt_tx: network-interface packet transmitter (header + up to 7 body flits, 16-bit flits).
// Optional output stall counter enabled by defining NI_TX_STALL_CNT_EN.
`default_nettype none

module ni_pkt_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  myaddr_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_dst_x_i,
  input  logic [1:0]  req_dst_y_i,
  input  logic [2:0]  req_len_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic [15:0] data_i,
  output logic [15:0] flit_o,
  output logic        flit_valid_o,
  input  logic        flit_ready_i,
  output logic        busy_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2,
    LAST = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] flit_q;
  logic        flit_valid_q;
  logic [2:0]  len_q;
  logic [2:0]  rem_q;
  logic [15:0] header_d;
  logic        data_acc;

  // Lowest set bit of a one-hot nibble; an empty nibble maps to index 0.
  function automatic logic [1:0] low_idx(input logic [3:0] n);
    if (n[0])      return 2'd0;
    else if (n[1]) return 2'd1;
    else if (n[2]) return 2'd2;
    else if (n[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  always_comb begin
    header_d = {1'b1, req_len_i,
                low_idx(myaddr_i[7:4]), low_idx(myaddr_i[3:0]),
                4'b0001 << req_dst_x_i, 4'b0001 << req_dst_y_i};
  end

  assign req_ready_o  = (state_q == IDLE);
  assign data_ready_o = (state_q == BODY) && (!flit_valid_q || flit_ready_i);
  assign data_acc     = data_valid_i && data_ready_o;
  assign flit_o       = flit_q;
  assign flit_valid_o = flit_valid_q;
  assign busy_o       = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flit_q       <= 16'h0000;
      flit_valid_q <= 1'b0;
      len_q        <= 3'd0;
      rem_q        <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            flit_q       <= header_d;
            flit_valid_q <= 1'b1;
            len_q        <= req_len_i;
            state_q      <= HEAD;
          end
        end
        HEAD: begin
          if (flit_ready_i) begin
            flit_valid_q <= 1'b0;
            if (len_q == 3'd0) begin
              state_q <= IDLE;
            end else begin
              rem_q   <= len_q;
              state_q <= BODY;
            end
          end
        end
        BODY: begin
          if (data_acc) begin
            flit_q       <= data_i;
            flit_valid_q <= 1'b1;
            rem_q        <= rem_q - 3'd1;
            if (rem_q == 3'd1) state_q <= LAST;
          end else if (flit_ready_i) begin
            flit_valid_q <= 1'b0;
          end
        end
        LAST: begin
          if (flit_ready_i) begin
            flit_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NI_TX_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts cycles the router refuses a presented flit; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'h0000;
    end else if (flit_valid_q && !flit_ready_i && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ni_pkt_tx.sv
// tb_ni_pkt_tx: directed self-checking bench for ni_pkt_tx.
`default_nettype none

module tb_ni_pkt_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  myaddr_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_dst_x_i;
  logic [1:0]  req_dst_y_i;
  logic [2:0]  req_len_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [15:0] data_i;
  logic [15:0] flit_o;
  logic        flit_valid_o;
  logic        flit_ready_i;
  logic        busy_o;
  logic [15:0] stall_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ni_pkt_tx dut (
    .clk          (clk),
    .rst          (rst),
    .myaddr_i     (myaddr_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_dst_x_i  (req_dst_x_i),
    .req_dst_y_i  (req_dst_y_i),
    .req_len_i    (req_len_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .flit_ready_i (flit_ready_i),
    .busy_o       (busy_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flit(input string tag, input logic v, input logic [15:0] f);
    chk({tag, "_valid"}, {31'd0, flit_valid_o}, {31'd0, v});
    if (v) chk({tag, "_flit"}, {16'd0, flit_o}, {16'd0, f});
  endtask

`ifdef NI_TX_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd5;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  initial begin
    rst = 1'b1; myaddr_i = 8'h12; req_valid_i = 1'b0; req_dst_x_i = 2'd0;
    req_dst_y_i = 2'd0; req_len_i = 3'd0; data_valid_i = 1'b0; data_i = 16'h0;
    flit_ready_i = 1'b1;
    tick(); tick();
    // reset state
    chk("rst_flit_valid", {31'd0, flit_valid_o}, 32'd0);
    chk("rst_flit", {16'd0, flit_o}, 32'h0);
    chk("rst_data_ready", {31'd0, data_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt_o}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    rst = 1'b0;

    // header-only packet to (2,0): src x idx 0, src y idx 1
    req_valid_i = 1'b1; req_dst_x_i = 2'd2; req_dst_y_i = 2'd0; req_len_i = 3'd0;
    tick();
    req_valid_i = 1'b0;
    chk_flit("p1_head", 1'b1, 16'h8141);
    chk("p1_busy", {31'd0, busy_o}, 32'd1);
    chk("p1_req_ready_busy", {31'd0, req_ready_o}, 32'd0);
    tick();
    chk_flit("p1_done", 1'b0, 16'h0);
    chk("p1_idle_busy", {31'd0, busy_o}, 32'd0);

    // len=3 to (3,3); request fields change after accept and must not matter
    req_valid_i = 1'b1; req_dst_x_i = 2'd3; req_dst_y_i = 2'd3; req_len_i = 3'd3;
    tick();
    req_valid_i = 1'b0; req_len_i = 3'd0; req_dst_x_i = 2'd0;
    chk_flit("p2_head", 1'b1, 16'hB188);
    data_valid_i = 1'b1; data_i = 16'hA1A1;
    tick();
    chk_flit("p2_gap", 1'b0, 16'h0);
    chk("p2_data_ready", {31'd0, data_ready_o}, 32'd1);
    tick();
    chk_flit("p2_b0", 1'b1, 16'hA1A1);
    data_i = 16'hB2B2;
    tick();
    chk_flit("p2_b1", 1'b1, 16'hB2B2);
    data_i = 16'hC3C3;
    tick();
    chk_flit("p2_b2", 1'b1, 16'hC3C3);
    chk("p2_last_data_ready", {31'd0, data_ready_o}, 32'd0);
    chk("p2_last_busy", {31'd0, busy_o}, 32'd1);
    data_valid_i = 1'b0;
    tick();
    chk_flit("p2_done", 1'b0, 16'h0);
    chk("p2_idle_busy", {31'd0, busy_o}, 32'd0);

    // header stalled for 5 cycles, to (1,2)
    flit_ready_i = 1'b0;
    req_valid_i = 1'b1; req_dst_x_i = 2'd1; req_dst_y_i = 2'd2; req_len_i = 3'd0;
    tick();
    req_valid_i = 1'b0;
    chk_flit("p3_head", 1'b1, 16'h8124);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_flit("p3_stall_hold", 1'b1, 16'h8124);
    end
    chk("p3_stall_cnt", {16'd0, stall_cnt_o}, {16'd0, STALL_EXP});
    flit_ready_i = 1'b1;
    tick();
    chk_flit("p3_done", 1'b0, 16'h0);
    chk("p3_stall_after", {16'd0, stall_cnt_o}, {16'd0, STALL_EXP});

    // len=2 to (0,1) with a 2-cycle payload gap
    req_valid_i = 1'b1; req_dst_x_i = 2'd0; req_dst_y_i = 2'd1; req_len_i = 3'd2;
    tick();
    req_valid_i = 1'b0;
    chk_flit("p4_head", 1'b1, 16'hA112);
    data_valid_i = 1'b1; data_i = 16'h1111;
    tick();
    tick();
    chk_flit("p4_b0", 1'b1, 16'h1111);
    data_valid_i = 1'b0;
    tick();
    chk_flit("p4_gap0", 1'b0, 16'h0);
    tick();
    chk_flit("p4_gap1", 1'b0, 16'h0);
    data_valid_i = 1'b1; data_i = 16'h2222;
    tick();
    chk_flit("p4_b1", 1'b1, 16'h2222);
    data_valid_i = 1'b0;
    tick();
    chk_flit("p4_done", 1'b0, 16'h0);
    chk("p4_idle_busy", {31'd0, busy_o}, 32'd0);

    // len=4 to (1,1), reset after the first body flit
    req_valid_i = 1'b1; req_dst_x_i = 2'd1; req_dst_y_i = 2'd1; req_len_i = 3'd4;
    tick();
    req_valid_i = 1'b0;
    chk_flit("p5_head", 1'b1, 16'hC122);
    data_valid_i = 1'b1; data_i = 16'hDEAD;
    tick();
    tick();
    chk_flit("p5_b0", 1'b1, 16'hDEAD);
    rst = 1'b1;
    tick();
    chk("p5_rst_valid", {31'd0, flit_valid_o}, 32'd0);
    chk("p5_rst_flit", {16'd0, flit_o}, 32'h0);
    chk("p5_rst_data_ready", {31'd0, data_ready_o}, 32'd0);
    chk("p5_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("p5_rst_stall", {16'd0, stall_cnt_o}, 32'd0);
    rst = 1'b0;
    tick();
    chk_flit("p5_abandoned", 1'b0, 16'h0);
    data_valid_i = 1'b0;
    req_valid_i = 1'b1; req_dst_x_i = 2'd2; req_dst_y_i = 2'd3; req_len_i = 3'd0;
    tick();
    req_valid_i = 1'b0;
    chk_flit("p5_fresh_head", 1'b1, 16'h8148);
    tick();
    chk_flit("p5_fresh_done", 1'b0, 16'h0);

    // req_valid held high: len=1 packets to (0,0) back to back
    req_valid_i = 1'b1; req_dst_x_i = 2'd0; req_dst_y_i = 2'd0; req_len_i = 3'd1;
    data_valid_i = 1'b1; data_i = 16'h5A5A;
    chk("p6_req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    tick();
    chk_flit("p6_head0", 1'b1, 16'h9111);
    chk("p6_req_ready_head", {31'd0, req_ready_o}, 32'd0);
    tick();
    chk("p6_req_ready_body", {31'd0, req_ready_o}, 32'd0);
    chk_flit("p6_body_gap", 1'b0, 16'h0);
    tick();
    chk_flit("p6_b0", 1'b1, 16'h5A5A);
    chk("p6_req_ready_last", {31'd0, req_ready_o}, 32'd0);
    tick();
    chk_flit("p6_bubble", 1'b0, 16'h0);
    chk("p6_req_ready_bubble", {31'd0, req_ready_o}, 32'd1);
    tick();
    req_valid_i = 1'b0;
    chk_flit("p6_head1", 1'b1, 16'h9111);
    tick();
    tick();
    chk_flit("p6_b1", 1'b1, 16'h5A5A);
    data_valid_i = 1'b0;
    tick();
    chk_flit("p6_done", 1'b0, 16'h0);
    tick();
    chk("p6_no_extra_busy", {31'd0, busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
